cmd_link_tx: RTL and testbench

- Host/base-station end of the vehicle command link. Accepts one 3-byte command (lmotor, rmotor, dur) and serialises it onto the vehicle's RX line as back-to-back UART frames.
- After sending, waits for the vehicle's ACK character 'A' (0x41) on its own RX pin.
- Retries the whole command on a bad or missing ACK. Reports done or fail to the host-side controller.

---
 rtl/cmd_link_tx.sv | 215 +++++++++++++++++++++
 tb/tb_cmd_link_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_link_tx.sv
`default_nettype none
// ============================================================================
// cmd_link_tx : sends a 3-byte motor command as UART frames, awaits ACK, retries
// Rev 1.0
// ============================================================================
module cmd_link_tx #(
  parameter int         CLKS_PER_BIT = 8,
  parameter int         ACK_TIMEOUT  = 4096,
  parameter int         MAX_RETRIES  = 3,
  parameter logic [7:0] ACK_CHAR     = 8'h41
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] lmotor,
  input  logic [7:0] rmotor,
  input  logic [7:0] dur,
  input  logic       RX,
  output logic       TX,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] attempt
);

  localparam int BT_W  = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(ACK_TIMEOUT);
  localparam int GAP_W = $clog2(16 * CLKS_PER_BIT);

  localparam logic [BT_W-1:0]  BIT_LAST  = BT_W'(CLKS_PER_BIT - 1);
  localparam logic [BT_W-1:0]  BIT_HALF  = BT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(16 * CLKS_PER_BIT - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SEND_START = 3'd1;
  localparam logic [2:0] S_SEND_DATA  = 3'd2;
  localparam logic [2:0] S_SEND_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT_ACK   = 3'd4;
  localparam logic [2:0] S_RX_ACK     = 3'd5;
  localparam logic [2:0] S_CHECK      = 3'd6;
  localparam logic [2:0] S_RESEND_GAP = 3'd7;

  logic [2:0]       state;
  logic [BT_W-1:0]  bit_tmr;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [3:0]       rx_idx;
  logic [TO_W-1:0]  tmo;
  logic [GAP_W-1:0] gap;
  logic [7:0]       shreg;
  logic [7:0]       lm_q;
  logic [7:0]       rm_q;
  logic [7:0]       dur_q;
  logic [7:0]       rx_byte;
  logic             rx_err;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  logic             rx_fall;

  assign rx_fall = rx_prev & ~rx_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_tmr  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      rx_idx   <= '0;
      tmo      <= '0;
      gap      <= '0;
      shreg    <= '0;
      lm_q     <= '0;
      rm_q     <= '0;
      dur_q    <= '0;
      rx_byte  <= '0;
      rx_err   <= 1'b0;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      TX       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      attempt  <= '0;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      done    <= 1'b0;
      fail    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lm_q     <= lmotor;
            rm_q     <= rmotor;
            dur_q    <= dur;
            shreg    <= lmotor;
            byte_idx <= '0;
            bit_tmr  <= '0;
            attempt  <= '0;
            busy     <= 1'b1;
            TX       <= 1'b0;
            state    <= S_SEND_START;
          end
        end
        S_SEND_START: begin
          if (bit_tmr == BIT_LAST) begin
            bit_tmr <= '0;
            bit_idx <= '0;
            TX      <= shreg[7];
            shreg   <= {shreg[6:0], 1'b0};
            state   <= S_SEND_DATA;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        S_SEND_DATA: begin
          if (bit_tmr == BIT_LAST) begin
            bit_tmr <= '0;
            if (bit_idx == 3'd7) begin
              TX    <= 1'b1;
              state <= S_SEND_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              TX      <= shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
            end
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        S_SEND_STOP: begin
          if (bit_tmr == BIT_LAST) begin
            bit_tmr <= '0;
            if (byte_idx == 2'd2) begin
              tmo    <= '0;
              rx_err <= 1'b0;
              state  <= S_WAIT_ACK;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              byte_idx <= byte_idx + 1'b1;
              shreg    <= (byte_idx == 2'd0) ? rm_q : dur_q;
              TX       <= 1'b0;
              state    <= S_SEND_START;
            end
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        S_WAIT_ACK: begin
          if (rx_fall) begin
            bit_tmr <= '0;
            rx_idx  <= '0;
            state   <= S_RX_ACK;
          end else if (tmo == TO_LAST) begin
            rx_err <= 1'b1;
            state  <= S_CHECK;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_RX_ACK: begin
          // Start bit is checked at half a bit, every later bit one full bit on.
          if (bit_tmr == ((rx_idx == 4'd0) ? BIT_HALF : BIT_LAST)) begin
            bit_tmr <= '0;
            if (rx_idx == 4'd0) begin
              if (rx_s2) state  <= S_WAIT_ACK;
              else       rx_idx <= 4'd1;
            end else if (rx_idx == 4'd9) begin
              if (!rx_s2) rx_err <= 1'b1;
              state <= S_CHECK;
            end else begin
              rx_byte <= {rx_byte[6:0], rx_s2};
              rx_idx  <= rx_idx + 1'b1;
            end
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        S_CHECK: begin
          if (!rx_err && rx_byte == ACK_CHAR) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (attempt < RETRY_MAX) begin
            attempt <= attempt + 1'b1;
            gap     <= '0;
            state   <= S_RESEND_GAP;
          end else begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_RESEND_GAP: begin
          if (gap == GAP_LAST) begin
            shreg    <= lm_q;
            byte_idx <= '0;
            bit_tmr  <= '0;
            TX       <= 1'b0;
            state    <= S_SEND_START;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_link_tx.sv
`default_nettype none
// Self-checking bench for cmd_link_tx: random commands, ACK replies, retries, reset.
module tb_cmd_link_tx;

  localparam int CPB = 4;
  localparam int TO  = 256;
  localparam int GAP = 16 * CPB;

  logic       clk = 1'b0;
  logic       reset, start, RX;
  logic [7:0] lmotor, rmotor, dur;
  logic       TX, busy, done, fail;
  logic [1:0] attempt;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int fail_cnt = 0;
  int pulse_busy_bad = 0;
  logic [1:0] last_att = '0;

  cmd_link_tx #(.CLKS_PER_BIT(CPB), .ACK_TIMEOUT(TO), .MAX_RETRIES(3), .ACK_CHAR(8'h41)) dut (
    .clk(clk), .reset(reset), .start(start), .lmotor(lmotor), .rmotor(rmotor), .dur(dur),
    .RX(RX), .TX(TX), .busy(busy), .done(done), .fail(fail), .attempt(attempt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) begin done_cnt++; last_att = attempt; if (busy !== 1'b0) pulse_busy_bad++; end
    if (fail === 1'b1) begin fail_cnt++; last_att = attempt; if (busy !== 1'b0) pulse_busy_bad++; end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    lmotor = a; rmotor = b; dur = c; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Reference: three frames of start(0), data MSB-first, stop(1); CPB cycles each bit.
  task automatic watch_stream(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input int poke_at, output int bad, output int busy_low);
    logic [7:0] by[3];
    bit exp[$];
    by[0] = a; by[1] = b; by[2] = c;
    for (int j = 0; j < 3; j++) begin
      exp.push_back(1'b0);
      for (int k = 7; k >= 0; k--) exp.push_back(by[j][k]);
      exp.push_back(1'b1);
    end
    bad = 0; busy_low = 0;
    for (int i = 0; i < 30 * CPB; i++) begin
      if (TX !== exp[i / CPB]) bad++;
      if (busy !== 1'b1) busy_low++;
      start = (i == poke_at);
      if (i == poke_at) begin lmotor = ~a; rmotor = ~b; dur = c ^ 8'h5A; end
      step(1);
    end
    start = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] v, input logic stop_bit);
    RX = 1'b0; step(CPB);
    for (int k = 7; k >= 0; k--) begin RX = v[k]; step(CPB); end
    RX = stop_bit; step(CPB);
    RX = 1'b1;
  endtask

  task automatic idle_len(input int bound, output int n);
    n = 0;
    while (TX === 1'b1 && n < bound) begin n++; step(1); end
  endtask

  task automatic wait_for(input int d0, input int f0, input int bound, output int n);
    n = 0;
    while (done_cnt == d0 && fail_cnt == f0 && n < bound) begin n++; step(1); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; RX = 1'b0;
    lmotor = 8'hFF; rmotor = 8'hFF; dur = 8'hFF;
    step(4);
    tests++; if (TX !== 1'b1) begin fails++; $display("FAIL reset_tx got=%b exp=1", TX); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (fail !== 1'b0) begin fails++; $display("FAIL reset_fail got=%b exp=0", fail); end
    tests++; if (attempt !== 2'd0) begin fails++; $display("FAIL reset_attempt got=%0d exp=0", attempt); end
    start = 1'b0; RX = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    tests++; if (TX !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL post_reset_idle tx=%b busy=%b exp tx=1 busy=0", TX, busy); end
  endtask

  task automatic test_nominal();
    int bad, bl, n, d0, f0;
    d0 = done_cnt; f0 = fail_cnt;
    launch(8'h85, 8'h05, 8'h20);
    watch_stream(8'h85, 8'h05, 8'h20, -1, bad, bl);
    tests++; if (bad != 0) begin fails++; $display("FAIL nominal_stream bad_cycles=%0d exp=0", bad); end
    tests++; if (bl != 0) begin fails++; $display("FAIL nominal_busy_low cycles=%0d exp=0", bl); end
    step(20);
    tests++; if (busy !== 1'b1 || TX !== 1'b1) begin fails++; $display("FAIL nominal_waiting busy=%b tx=%b exp 1 1", busy, TX); end
    drive_rx(8'h41, 1'b1);
    wait_for(d0, f0, 60, n);
    step(5);
    tests++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL nominal_done count=%0d exp=%0d", done_cnt - d0, 1); end
    tests++; if (fail_cnt != f0) begin fails++; $display("FAIL nominal_no_fail count=%0d exp=0", fail_cnt - f0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nominal_busy_after got=%b exp=0", busy); end
    tests++; if (last_att !== 2'd0) begin fails++; $display("FAIL nominal_attempt got=%0d exp=0", last_att); end
  endtask

  task automatic test_wrong_ack();
    logic [7:0] a, b, c;
    int bad, bl, n, d0, f0;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    d0 = done_cnt; f0 = fail_cnt;
    launch(a, b, c);
    watch_stream(a, b, c, -1, bad, bl);
    tests++; if (bad != 0) begin fails++; $display("FAIL wrong_first_stream bad_cycles=%0d exp=0", bad); end
    step($urandom_range(1, 60));
    drive_rx(8'h42, 1'b1);
    idle_len(300, n);
    tests++; if (n < GAP - 4 || n > GAP + 8) begin fails++; $display("FAIL wrong_gap len=%0d exp~%0d", n, GAP); end
    tests++; if (attempt !== 2'd1) begin fails++; $display("FAIL wrong_attempt got=%0d exp=1", attempt); end
    watch_stream(a, b, c, -1, bad, bl);
    tests++; if (bad != 0) begin fails++; $display("FAIL wrong_resend_stream bad_cycles=%0d exp=0", bad); end
    drive_rx(8'h41, 1'b1);
    wait_for(d0, f0, 60, n);
    tests++; if (done_cnt != d0 + 1 || last_att !== 2'd1) begin fails++; $display("FAIL wrong_done count=%0d att=%0d exp 1 1", done_cnt - d0, last_att); end
  endtask

  task automatic test_timeout_fail();
    logic [7:0] a, b, c;
    int bad, bl, n, d0, f0;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    d0 = done_cnt; f0 = fail_cnt;
    launch(a, b, c);
    for (int k = 0; k < 4; k++) begin
      tests++; if (attempt !== 2'(k)) begin fails++; $display("FAIL tmo_attempt got=%0d exp=%0d", attempt, k); end
      watch_stream(a, b, c, -1, bad, bl);
      tests++; if (bad != 0) begin fails++; $display("FAIL tmo_stream%0d bad_cycles=%0d exp=0", k, bad); end
      if (k < 3) begin
        idle_len(600, n);
        tests++; if (n < TO + GAP || n > TO + GAP + 8) begin fails++; $display("FAIL tmo_idle%0d len=%0d exp~%0d", k, n, TO + GAP); end
      end
    end
    wait_for(d0, f0, 400, n);
    tests++; if (n < TO || n > TO + 6) begin fails++; $display("FAIL tmo_fail_delay got=%0d exp~%0d", n, TO); end
    step(3);
    tests++; if (fail_cnt != f0 + 1) begin fails++; $display("FAIL tmo_fail_pulse count=%0d exp=1", fail_cnt - f0); end
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL tmo_no_done count=%0d exp=0", done_cnt - d0); end
    tests++; if (last_att !== 2'd3 || attempt !== 2'd3) begin fails++; $display("FAIL tmo_final_attempt got=%0d/%0d exp=3", last_att, attempt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL tmo_busy got=%b exp=0", busy); end
  endtask

  task automatic test_glitch();
    logic [7:0] a, b, c;
    int bad, bl, n, d0, f0;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    d0 = done_cnt; f0 = fail_cnt;
    launch(a, b, c);
    watch_stream(a, b, c, -1, bad, bl);
    step(10);
    RX = 1'b0; step(1); RX = 1'b1;
    step(30);
    tests++; if (busy !== 1'b1 || TX !== 1'b1 || done_cnt != d0 || fail_cnt != f0) begin
      fails++; $display("FAIL glitch_still_waiting busy=%b tx=%b done=%0d fail=%0d exp 1 1 0 0", busy, TX, done_cnt - d0, fail_cnt - f0);
    end
    drive_rx(8'h41, 1'b1);
    wait_for(d0, f0, 60, n);
    tests++; if (done_cnt != d0 + 1 || last_att !== 2'd0) begin fails++; $display("FAIL glitch_done count=%0d att=%0d exp 1 0", done_cnt - d0, last_att); end
    d0 = done_cnt;
    launch(c, a, b);
    watch_stream(c, a, b, -1, bad, bl);
    drive_rx(8'h41, 1'b0);
    idle_len(300, n);
    tests++; if (n < GAP - 4 || n > GAP + 8) begin fails++; $display("FAIL framing_gap len=%0d exp~%0d", n, GAP); end
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL framing_no_done count=%0d exp=0", done_cnt - d0); end
    watch_stream(c, a, b, -1, bad, bl);
    tests++; if (bad != 0) begin fails++; $display("FAIL framing_resend_stream bad_cycles=%0d exp=0", bad); end
    drive_rx(8'h41, 1'b1);
    wait_for(d0, f0, 60, n);
    tests++; if (done_cnt != d0 + 1 || last_att !== 2'd1) begin fails++; $display("FAIL framing_done count=%0d att=%0d exp 1 1", done_cnt - d0, last_att); end
  endtask

  task automatic test_start_ignored();
    logic [7:0] a, b, c;
    int bad, bl, n, d0, f0, noisy;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    d0 = done_cnt; f0 = fail_cnt;
    launch(a, b, c);
    watch_stream(a, b, c, 50, bad, bl);
    tests++; if (bad != 0) begin fails++; $display("FAIL ignore_stream bad_cycles=%0d exp=0", bad); end
    drive_rx(8'h41, 1'b1);
    wait_for(d0, f0, 60, n);
    noisy = 0;
    for (int i = 0; i < 200; i++) begin
      if (TX !== 1'b1 || busy !== 1'b0) noisy++;
      step(1);
    end
    tests++; if (noisy != 0 || done_cnt != d0 + 1) begin fails++; $display("FAIL ignore_no_second_cmd active=%0d done=%0d exp 0 1", noisy, done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, b, c;
    int bad, bl, n, d0, f0;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    launch(a, b, c);
    step(50);
    reset = 1'b1;
    step(1);
    tests++; if (TX !== 1'b1 || busy !== 1'b0 || attempt !== 2'd0) begin
      fails++; $display("FAIL midreset_outputs tx=%b busy=%b att=%0d exp 1 0 0", TX, busy, attempt);
    end
    step(2);
    reset = 1'b0;
    step(2);
    d0 = done_cnt; f0 = fail_cnt;
    launch(b, c, a);
    watch_stream(b, c, a, -1, bad, bl);
    tests++; if (bad != 0) begin fails++; $display("FAIL midreset_clean_stream bad_cycles=%0d exp=0", bad); end
    drive_rx(8'h41, 1'b1);
    wait_for(d0, f0, 60, n);
    tests++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL midreset_done count=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, c;
    int bad, bl, n, d0, f0;
    for (int r = 0; r < 4; r++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      d0 = done_cnt; f0 = fail_cnt;
      launch(a, b, c);
      watch_stream(a, b, c, -1, bad, bl);
      tests++; if (bad != 0 || bl != 0) begin fails++; $display("FAIL b2b_stream%0d bad=%0d busy_low=%0d exp 0 0", r, bad, bl); end
      step($urandom_range(0, 100));
      drive_rx(8'h41, 1'b1);
      wait_for(d0, f0, 60, n);
      tests++; if (done_cnt != d0 + 1 || fail_cnt != f0) begin fails++; $display("FAIL b2b_done%0d done=%0d fail=%0d exp 1 0", r, done_cnt - d0, fail_cnt - f0); end
    end
    tests++; if (pulse_busy_bad != 0) begin fails++; $display("FAIL pulse_busy_overlap count=%0d exp=0", pulse_busy_bad); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; RX = 1'b1;
    lmotor = '0; rmotor = '0; dur = '0;
    test_reset();
    test_nominal();
    test_wrong_ack();
    test_timeout_fail();
    test_glitch();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
